// File: rtl/div_share_arbiter.sv
// div_share_arbiter
//   Shares one sequential 16-bit divider between two requesters using
//   round-robin arbitration. It sequences the divider's start/done
//   handshake, holds the operands while an operation runs, and returns the
//   quotient, remainder and error status to the requester that won.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   req0/a0/b0          requester 0 request level, dividend, divisor
//   req1/a1/b1          requester 1 request level, dividend, divisor
//   ack0, ack1          one-cycle result-valid pulse for each requester
//   q, r, err           quotient, remainder and error flag (valid with ack)
//   busy                low only while idle
//   div_start           one-cycle start pulse to the divider
//   div_a, div_b        operands driven to the divider
//   div_done            divider completion strobe
//   div_q, div_r        divider results, sampled with div_done
//
// Parameters
//   TIMEOUT             cycles to wait for div_done before failing (> 1)
//   CNT_W               timeout counter width, 2**CNT_W > TIMEOUT
module div_share_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [15:0] a0,
  input  logic [15:0] b0,
  input  logic        req1,
  input  logic [15:0] a1,
  input  logic [15:0] b1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] q,
  output logic [15:0] r,
  output logic        err,
  output logic        busy,
  output logic        div_start,
  output logic [15:0] div_a,
  output logic [15:0] div_b,
  input  logic        div_done,
  input  logic [15:0] div_q,
  input  logic [15:0] div_r
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    ZERO  = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t             state;
  logic               owner;
  logic               last_grant;
  logic [CNT_W-1:0]   cnt;

  logic               grant1;
  logic [15:0]        sel_a;
  logic [15:0]        sel_b;

  // Requester 1 wins when it is the only one asking, or when both ask and
  // requester 0 was served last.
  always_comb begin
    grant1 = req1 && (!req0 || !last_grant);
    sel_a  = grant1 ? a1 : a0;
    sel_b  = grant1 ? b1 : b0;
  end

  // Handshake outputs decode straight from the state so they are clean
  // single-cycle pulses that drop to zero the moment reset forces IDLE.
  always_comb begin
    busy      = (state != IDLE);
    div_start = (state == START);
    ack0      = (state == RESP) && !owner;
    ack1      = (state == RESP) &&  owner;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      div_a      <= '0;
      div_b      <= '0;
      q          <= '0;
      r          <= '0;
      err        <= 1'b0;
      cnt        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner <= grant1;
            div_a <= sel_a;
            div_b <= sel_b;
            state <= (sel_b == '0) ? ZERO : START;
          end
        end
        START: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (div_done) begin
            q     <= div_q;
            r     <= div_r;
            err   <= 1'b0;
            state <= RESP;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            q     <= '1;
            r     <= '0;
            err   <= 1'b1;
            state <= RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ZERO: begin
          // Divide-by-zero never reaches the divider; the dividend is
          // returned as the remainder.
          q     <= '1;
          r     <= div_a;
          err   <= 1'b1;
          state <= RESP;
        end
        RESP: begin
          last_grant <= owner;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
